pc_seq_unit: RTL and testbench
==============================

// Module: pc_seq_unit
// PURPOSE
//  Parametrised program-counter sequencer for the single-issue core; replaces the fixed 8-bit PC.
//  Launches one of NUM_PROGS programs from a start-address table on a start pulse.
//  Takes relative conditional/unconditional branches, plus CALL/RET through a return-address stack.
//  Supports stall and halt; reports status to the testbench/top level.
// PARAMETERS
//  PC_W       8            PC width; all PC arithmetic is modulo 2**PC_W
//  OFF_W      8            branch offset width; two's complement, sign-extended to PC_W
//  NUM_PROGS  3            number of program entry points
//  PROG_BASE  {8'd44,8'd25,8'd0}  packed NUM_PROGS*PC_W start table; entry i = bits [i*PC_W +: PC_W]
//  RAS_DEPTH  4            return-address stack entries (>=1)
// PORTS
//  clk       in   1                       clock, rising edge
//  reset     in   1                       asynchronous, active-low reset
//  start     in   1                       1-cycle pulse: launch program prog_sel
//  prog_sel  in   $clog2(NUM_PROGS)       program index, sampled with start
//  stall     in   1                       hold PC/state this cycle
//  ctrl      in   3                       flow op: 0 SEQ,1 BA,2 BL,3 BG,4 BE,5 CALL,6 RET,7 HALT
//  z         in   1                       zero flag (for BE)
//  lt        in   1                       less-than flag (for BL; BG taken when !lt)
//  offset    in   OFF_W                   signed branch/call displacement
//  pc        out  PC_W                    current fetch address
//  running   out  1                       1 while in RUN
//  done      out  1                       1-cycle pulse on HALT entry
//  err       out  1                       sticky: RAS overflow/underflow or bad prog_sel
//  ras_cnt   out  $clog2(RAS_DEPTH+1)     current RAS occupancy
// BEHAVIOUR
//  Reset (async, reset==0)
//   - pc=0, state=IDLE, running=0, done=0, err=0, ras_cnt=0.
//   - Applies immediately, including mid-program; RAS contents are discarded.
//  States: IDLE, RUN, HALT. All updates on rising clk; pc changes one cycle after the controlling inputs.
//  start (any state; highest priority; overrides stall and ctrl)
//   - prog_sel < NUM_PROGS: pc<=PROG_BASE[prog_sel].
//   - prog_sel >= NUM_PROGS: pc<=PROG_BASE[0] and err<=1.
//   - Always: state<=RUN, ras_cnt<=0, done<=0. err is otherwise unchanged (cleared only by reset).
//  IDLE / HALT without start: pc holds; ctrl and stall are ignored.
//  RUN, stall=1: pc, RAS and state all hold; ctrl is ignored.
//  RUN, stall=0, by ctrl:
//   - SEQ: pc<=pc+1.
//   - BA: pc<=pc+sext(offset).
//   - BL: if lt, pc<=pc+sext(offset); else pc<=pc+1.
//   - BG: if !lt, pc<=pc+sext(offset); else pc<=pc+1.
//   - BE: if z, pc<=pc+sext(offset); else pc<=pc+1.
//   - CALL: push pc+1, then pc<=pc+sext(offset).
//     - If the RAS is full: no push, err<=1, branch still taken.
//   - RET: pop, pc<=top.
//     - If the RAS is empty: err<=1, pc<=pc+1.
//   - HALT: pc holds; state<=HALT; done pulses high for exactly the next cycle.
//  Arithmetic and reset values
//   - All adds wrap modulo 2**PC_W: e.g. pc=255 + 1 gives 0; pc=2 + sext(-4) gives 254 (PC_W=8).
//   - RAS entries are not reset-cleared in storage; only ras_cnt is reset-cleared.
//   - running = (state==RUN), registered.
// TESTING
//  1. Reset low mid-RUN at pc=30 -> pc=0, running=0, ras_cnt=0, err=0 with no clk edge.
//  2. start, prog_sel=1 -> next cycle pc=25, running=1; 3x SEQ -> pc=28; prog_sel=3 -> pc=0, err=1.
//  3. pc=40: BL, lt=1, offset=-5 -> pc=35; BG, lt=1 -> pc=36; BE, z=1, offset=+4 -> pc=40; BA, offset=-128 at pc=10 -> pc=138.
//  4. pc=50: CALL +10 -> pc=60, ras_cnt=1; RET -> pc=51, ras_cnt=0; RET again -> err=1, pc=52.
//     5 nested CALLs with RAS_DEPTH=4 -> err=1, ras_cnt=4.
//  5. Hold stall=1 for 3 cycles with ctrl=BA -> pc unchanged; start together with stall -> start wins, pc=PROG_BASE[sel].
//  6. HALT at pc=70 -> done high exactly 1 cycle, pc stays 70, running=0; later SEQ ignored; start sel=2 -> pc=44, running=1.

Source files
------------

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: launches programs from a start table, takes relative
// branches and CALL/RET through a small return-address stack, with stall and halt.
module pc_seq_unit #(
    parameter int                         PC_W      = 8,
    parameter int                         OFF_W     = 8,
    parameter int                         NUM_PROGS = 3,
    parameter logic [NUM_PROGS*PC_W-1:0]  PROG_BASE = {8'd44, 8'd25, 8'd0},
    parameter int                         RAS_DEPTH = 4,
    localparam int                        SEL_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
    localparam int                        CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [SEL_W-1:0]        prog_sel,
    input  logic                    stall,
    input  logic [2:0]              ctrl,
    input  logic                    z,
    input  logic                    lt,
    input  logic signed [OFF_W-1:0] offset,
    output logic [PC_W-1:0]         pc,
    output logic                    running,
    output logic                    done,
    output logic                    err,
    output logic [CNT_W-1:0]        ras_cnt
);

    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
    typedef enum logic [2:0] {
        OP_SEQ, OP_BA, OP_BL, OP_BG, OP_BE, OP_CALL, OP_RET, OP_HALT
    } op_t;

    state_t            state;
    op_t               op;
    logic [PC_W-1:0]   ras [2**IDX_W];
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_br;
    logic [PC_W-1:0]   start_pc;
    logic [SEL_W-1:0]  start_idx;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;
    logic              sel_ok;
    logic              adv;
    logic              ras_full;
    logic              ras_empty;
    logic              push_en;

    // Sign-extend (or wrap) the displacement to PC width; arithmetic is modulo 2**PC_W.
    function automatic logic [PC_W-1:0] sext(input logic signed [OFF_W-1:0] o);
        logic signed [PC_W-1:0] w;
        w = PC_W'(o);
        return w;
    endfunction

    always_comb begin
        op        = op_t'(ctrl);
        pc_inc    = pc + PC_W'(1);
        pc_br     = pc + sext(offset);
        sel_ok    = 32'(prog_sel) < NUM_PROGS;
        start_idx = sel_ok ? prog_sel : '0;
        start_pc  = PROG_BASE[int'(start_idx)*PC_W +: PC_W];
        ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
        ras_empty = (ras_cnt == '0);
        push_idx  = IDX_W'(ras_cnt);
        pop_idx   = IDX_W'(ras_cnt - CNT_W'(1));
        adv       = (state == S_RUN) && !stall && !start;
        push_en   = adv && (op == OP_CALL) && !ras_full;
    end

    // Stack storage carries no reset; only the occupancy count is cleared.
    always_ff @(posedge clk) begin
        if (push_en) begin
            ras[push_idx] <= pc_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            ras_cnt <= '0;
        end else if (start) begin
            state   <= S_RUN;
            pc      <= start_pc;
            running <= 1'b1;
            done    <= 1'b0;
            ras_cnt <= '0;
            if (!sel_ok) begin
                err <= 1'b1;
            end
        end else begin
            done <= 1'b0;
            if (adv) begin
                case (op)
                    OP_SEQ:  pc <= pc_inc;
                    OP_BA:   pc <= pc_br;
                    OP_BL:   pc <= lt ? pc_br : pc_inc;
                    OP_BG:   pc <= !lt ? pc_br : pc_inc;
                    OP_BE:   pc <= z ? pc_br : pc_inc;
                    OP_CALL: begin
                        pc <= pc_br;
                        if (ras_full) begin
                            err <= 1'b1;
                        end else begin
                            ras_cnt <= ras_cnt + CNT_W'(1);
                        end
                    end
                    OP_RET: begin
                        if (ras_empty) begin
                            err <= 1'b1;
                            pc  <= pc_inc;
                        end else begin
                            pc      <= ras[pop_idx];
                            ras_cnt <= ras_cnt - CNT_W'(1);
                        end
                    end
                    OP_HALT: begin
                        state   <= S_HALT;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end
                    default: pc <= pc;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Scoreboard bench for pc_seq_unit: expected status is queued when a cycle is driven,
// the observed status is queued after the edge, and each scenario drains both queues.
module tb_pc_seq_unit;

    localparam logic [2:0] SEQ = 3'd0, BA = 3'd1, BL = 3'd2, BG = 3'd3,
                           BE = 3'd4, CALL = 3'd5, RET = 3'd6, HALT = 3'd7;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        prog_sel = '0;
    logic              stall = 1'b0;
    logic [2:0]        ctrl = '0;
    logic              z = 1'b0;
    logic              lt = 1'b0;
    logic signed [7:0] offset = '0;
    logic [7:0]        pc;
    logic              running;
    logic              done;
    logic              err;
    logic [2:0]        ras_cnt;

    int errors = 0;
    int checks = 0;
    logic [13:0] expq[$];
    logic [13:0] obsq[$];
    string       nameq[$];

    always #5 clk = ~clk;

    pc_seq_unit dut (
        .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .stall(stall),
        .ctrl(ctrl), .z(z), .lt(lt), .offset(offset), .pc(pc), .running(running),
        .done(done), .err(err), .ras_cnt(ras_cnt)
    );

    function automatic logic [13:0] st(input int p, input int r, input int d, input int e, input int c);
        return {p[7:0], r[0], d[0], e[0], c[2:0]};
    endfunction

    task automatic drive(input logic s, input logic [1:0] sel, input logic stl, input logic [2:0] o,
                         input logic l, input logic zz, input logic [7:0] off,
                         input logic [13:0] e, input string nm);
        @(negedge clk);
        start = s; prog_sel = sel; stall = stl; ctrl = o; lt = l; z = zz; offset = off;
        expq.push_back(e);
        nameq.push_back(nm);
        @(posedge clk);
        #1;
        obsq.push_back({pc, running, done, err, ras_cnt});
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic op(input logic [2:0] o, input logic [7:0] off, input logic l, input logic zz,
                      input logic [13:0] e, input string nm);
        drive(1'b0, 2'd0, 1'b0, o, l, zz, off, e, nm);
    endtask

    task automatic go(input logic [1:0] sel, input logic [13:0] e, input string nm);
        drive(1'b1, sel, 1'b0, SEQ, 1'b0, 1'b0, 8'd0, e, nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; start = 1'b0; stall = 1'b0; ctrl = SEQ;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [13:0] e, o;
        string n;
        repeat (2) @(posedge clk);
        #1;
        expq.push_back(st(0, 0, 0, 0, 0)); nameq.push_back("reset_state");
        obsq.push_back({pc, running, done, err, ras_cnt});
        @(negedge clk);
        reset = 1'b1;
        go(2'd3, st(0, 1, 0, 1, 0), "bad_sel_pre");
        go(2'd1, st(25, 1, 0, 1, 0), "start1_pre");
        for (int i = 1; i <= 5; i++) op(SEQ, 8'd0, 0, 0, st(25 + i, 1, 0, 1, 0), "seq_to_30");
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        expq.push_back(st(0, 0, 0, 0, 0)); nameq.push_back("async_reset_mid_run");
        obsq.push_back({pc, running, done, err, ras_cnt});
        @(negedge clk);
        reset = 1'b1;
        while (expq.size() > 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); n = nameq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got pc=%0d run=%b done=%b err=%b ras=%0d, expected pc=%0d run=%b done=%b err=%b ras=%0d",
                         n, o[13:6], o[5], o[4], o[3], o[2:0], e[13:6], e[5], e[4], e[3], e[2:0]);
            end
        end
    endtask

    task automatic test_start_seq();
        logic [13:0] e, o;
        string n;
        do_reset();
        go(2'd1, st(25, 1, 0, 0, 0), "start_sel1");
        for (int i = 1; i <= 3; i++) op(SEQ, 8'd0, 0, 0, st(25 + i, 1, 0, 0, 0), "seq");
        go(2'd3, st(0, 1, 0, 1, 0), "bad_sel");
        op(SEQ, 8'd0, 0, 0, st(1, 1, 0, 1, 0), "err_sticky");
        while (expq.size() > 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); n = nameq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got pc=%0d run=%b done=%b err=%b ras=%0d, expected pc=%0d run=%b done=%b err=%b ras=%0d",
                         n, o[13:6], o[5], o[4], o[3], o[2:0], e[13:6], e[5], e[4], e[3], e[2:0]);
            end
        end
    endtask

    task automatic test_branch();
        logic [13:0] e, o;
        string n;
        do_reset();
        go(2'd2, st(44, 1, 0, 0, 0), "start_sel2");
        op(BA, 8'hFC, 0, 0, st(40, 1, 0, 0, 0), "ba_back4");
        op(BL, 8'hFB, 1, 0, st(35, 1, 0, 0, 0), "bl_taken");
        op(BG, 8'hFB, 1, 0, st(36, 1, 0, 0, 0), "bg_not_taken");
        op(BE, 8'h04, 0, 1, st(40, 1, 0, 0, 0), "be_taken");
        op(BL, 8'h10, 0, 0, st(41, 1, 0, 0, 0), "bl_not_taken");
        op(BG, 8'h02, 0, 0, st(43, 1, 0, 0, 0), "bg_taken");
        op(BE, 8'h10, 0, 0, st(44, 1, 0, 0, 0), "be_not_taken");
        op(BA, 8'hDE, 0, 0, st(10, 1, 0, 0, 0), "ba_to_10");
        op(BA, 8'h80, 0, 0, st(138, 1, 0, 0, 0), "ba_minus128");
        op(BA, 8'h75, 0, 0, st(255, 1, 0, 0, 0), "ba_to_255");
        op(SEQ, 8'd0, 0, 0, st(0, 1, 0, 0, 0), "seq_wrap");
        op(SEQ, 8'd0, 0, 0, st(1, 1, 0, 0, 0), "seq_1");
        op(SEQ, 8'd0, 0, 0, st(2, 1, 0, 0, 0), "seq_2");
        op(BA, 8'hFC, 0, 0, st(254, 1, 0, 0, 0), "ba_wrap_down");
        while (expq.size() > 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); n = nameq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got pc=%0d run=%b done=%b err=%b ras=%0d, expected pc=%0d run=%b done=%b err=%b ras=%0d",
                         n, o[13:6], o[5], o[4], o[3], o[2:0], e[13:6], e[5], e[4], e[3], e[2:0]);
            end
        end
    endtask

    task automatic test_call_ret();
        logic [13:0] e, o;
        string n;
        do_reset();
        go(2'd2, st(44, 1, 0, 0, 0), "start_sel2");
        op(BA, 8'd6, 0, 0, st(50, 1, 0, 0, 0), "ba_to_50");
        op(CALL, 8'd10, 0, 0, st(60, 1, 0, 0, 0) | 14'd1, "call");
        op(RET, 8'd0, 0, 0, st(51, 1, 0, 0, 0), "ret");
        op(RET, 8'd0, 0, 0, st(52, 1, 0, 1, 0), "ret_underflow");
        do_reset();
        go(2'd0, st(0, 1, 0, 0, 0), "start_sel0");
        for (int i = 1; i <= 4; i++) op(CALL, 8'd10, 0, 0, st(10 * i, 1, 0, 0, i), "nested_call");
        op(CALL, 8'd10, 0, 0, st(50, 1, 0, 1, 4), "call_overflow");
        op(RET, 8'd0, 0, 0, st(31, 1, 0, 1, 3), "ret_lifo3");
        op(RET, 8'd0, 0, 0, st(21, 1, 0, 1, 2), "ret_lifo2");
        op(RET, 8'd0, 0, 0, st(11, 1, 0, 1, 1), "ret_lifo1");
        op(RET, 8'd0, 0, 0, st(1, 1, 0, 1, 0), "ret_lifo0");
        while (expq.size() > 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); n = nameq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got pc=%0d run=%b done=%b err=%b ras=%0d, expected pc=%0d run=%b done=%b err=%b ras=%0d",
                         n, o[13:6], o[5], o[4], o[3], o[2:0], e[13:6], e[5], e[4], e[3], e[2:0]);
            end
        end
    endtask

    task automatic test_stall();
        logic [13:0] e, o;
        string n;
        do_reset();
        go(2'd1, st(25, 1, 0, 0, 0), "start_sel1");
        for (int i = 0; i < 3; i++) drive(0, 0, 1, BA, 0, 0, 8'd5, st(25, 1, 0, 0, 0), "stall_ba");
        op(BA, 8'd5, 0, 0, st(30, 1, 0, 0, 0), "ba_after_stall");
        drive(0, 0, 1, CALL, 0, 0, 8'd10, st(30, 1, 0, 0, 0), "stall_call");
        op(CALL, 8'd10, 0, 0, st(40, 1, 0, 0, 1), "call_after_stall");
        drive(1, 2'd2, 1, BA, 0, 0, 8'd5, st(44, 1, 0, 0, 0), "start_beats_stall");
        op(RET, 8'd0, 0, 0, st(45, 1, 0, 1, 0), "ret_after_start_empty");
        while (expq.size() > 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); n = nameq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got pc=%0d run=%b done=%b err=%b ras=%0d, expected pc=%0d run=%b done=%b err=%b ras=%0d",
                         n, o[13:6], o[5], o[4], o[3], o[2:0], e[13:6], e[5], e[4], e[3], e[2:0]);
            end
        end
    endtask

    task automatic test_halt();
        logic [13:0] e, o;
        string n;
        do_reset();
        op(SEQ, 8'd0, 0, 0, st(0, 0, 0, 0, 0), "idle_ignores_seq");
        go(2'd2, st(44, 1, 0, 0, 0), "start_sel2");
        op(BA, 8'd26, 0, 0, st(70, 1, 0, 0, 0), "ba_to_70");
        drive(0, 0, 1, HALT, 0, 0, 8'd0, st(70, 1, 0, 0, 0), "stall_halt");
        op(HALT, 8'd0, 0, 0, st(70, 0, 1, 0, 0), "halt_entry");
        op(SEQ, 8'd0, 0, 0, st(70, 0, 0, 0, 0), "halt_seq_ignored");
        op(BA, 8'd5, 0, 0, st(70, 0, 0, 0, 0), "halt_ba_ignored");
        go(2'd2, st(44, 1, 0, 0, 0), "restart_sel2");
        op(SEQ, 8'd0, 0, 0, st(45, 1, 0, 0, 0), "seq_after_restart");
        while (expq.size() > 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); n = nameq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got pc=%0d run=%b done=%b err=%b ras=%0d, expected pc=%0d run=%b done=%b err=%b ras=%0d",
                         n, o[13:6], o[5], o[4], o[3], o[2:0], e[13:6], e[5], e[4], e[3], e[2:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] e, o;
        string n;
        do_reset();
        go(2'd0, st(0, 1, 0, 0, 0), "b2b_start0");
        go(2'd1, st(25, 1, 0, 0, 0), "b2b_start1");
        go(2'd2, st(44, 1, 0, 0, 0), "b2b_start2");
        op(CALL, 8'hFC, 0, 0, st(40, 1, 0, 0, 1), "b2b_call_back");
        op(RET, 8'd0, 0, 0, st(45, 1, 0, 0, 0), "b2b_ret");
        op(HALT, 8'd0, 0, 0, st(45, 0, 1, 0, 0), "b2b_halt");
        go(2'd1, st(25, 1, 0, 0, 0), "b2b_start_in_halt");
        while (expq.size() > 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); n = nameq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s: got pc=%0d run=%b done=%b err=%b ras=%0d, expected pc=%0d run=%b done=%b err=%b ras=%0d",
                         n, o[13:6], o[5], o[4], o[3], o[2:0], e[13:6], e[5], e[4], e[3], e[2:0]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_start_seq();
        test_branch();
        test_call_ret();
        test_stall();
        test_halt();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
